nd_array_row_packer: RTL and testbench

- Reassembles a packed N-d array from a stream of row slices, one row per beat. This is the inverse of the row-slicing that splits an N-d array into sub-arrays.
- Accepts rows of COLS elements of WIDTH bits over a valid/ready handshake and stores them into a ROWS x COLS array register.
- Presents the completed frame as an unpacked 2-d output array with its own valid/ready handshake.
- Sits between streaming producers and consumers that take whole N-d array ports.

---
 rtl/nd_array_row_packer.sv | 130 +++++++++++++
 tb/tb_nd_array_row_packer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nd_array_row_packer.sv
`default_nettype none
// =============================================================================
// Module   : nd_array_row_packer
// Purpose  : Rebuilds a ROWS x COLS frame from a stream of rows, one row per beat.
// Options  : NDPACK_LAST_CHECK_EN adds I_last framing with a sticky O_err flag.
// Revision : 1.0 - initial release
// =============================================================================
module nd_array_row_packer #(
  parameter int WIDTH  = 8,
  parameter int COLS   = 16,
  parameter int ROWS   = 4,
  parameter int FCNT_W = 8
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  input  logic [WIDTH-1:0]  I0 [COLS],
  input  logic              I_valid,
  output logic              I_ready,
`ifdef NDPACK_LAST_CHECK_EN
  input  logic              I_last,
  output logic              O_err,
`endif
  output logic [WIDTH-1:0]  O0 [ROWS][COLS],
  output logic              O_valid,
  input  logic              O_ready,
  output logic [FCNT_W-1:0] O_frames
);

  localparam int               c_IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(ROWS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic [c_IDX_W-1:0]   w_wr_idx;
  logic [WIDTH-1:0]     r_data [ROWS][COLS];
  logic [FCNT_W-1:0]    r_frames;
  logic                 w_accept;
  logic                 w_handoff;
  logic                 w_early;
  logic                 w_close;

  assign I_ready   = (r_state == FILL) | O_ready;
  assign w_accept  = I_valid & I_ready;
  assign w_handoff = (r_state == FULL) & O_ready;
  // A row accepted while FULL rides on the handoff and opens the next frame.
  assign w_wr_idx  = (r_state == FULL) ? '0 : r_idx;

`ifdef NDPACK_LAST_CHECK_EN
  assign w_early = I_last & (w_wr_idx != c_LAST_IDX);
`else
  assign w_early = 1'b0;
`endif
  assign w_close = (w_wr_idx == c_LAST_IDX) | w_early;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_accept) begin
      if (w_close) begin
        w_state_nxt = FULL;
        w_idx_nxt   = '0;
      end else begin
        w_state_nxt = FILL;
        w_idx_nxt   = w_wr_idx + 1'b1;
      end
    end else if (w_handoff) begin
      w_state_nxt = FILL;
      w_idx_nxt   = '0;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_data[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int c = 0; c < COLS; c++) begin
        r_data[w_wr_idx][c] <= I0[c];
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_frames <= '0;
    end else if (w_handoff) begin
      r_frames <= r_frames + 1'b1;
    end
  end

`ifdef NDPACK_LAST_CHECK_EN
  logic r_err;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_err <= 1'b0;
    end else if (w_accept && (I_last != (w_wr_idx == c_LAST_IDX))) begin
      r_err <= 1'b1;
    end
  end

  assign O_err = r_err;
`endif

  assign O0       = r_data;
  assign O_valid  = (r_state == FULL);
  assign O_frames = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_nd_array_row_packer.sv
`default_nettype none
// =============================================================================
// Module   : tb_nd_array_row_packer
// Purpose  : Scoreboard bench for nd_array_row_packer with a frame-level model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_nd_array_row_packer;

  localparam int WIDTH  = 8;
  localparam int COLS   = 2;
  localparam int ROWS   = 4;
  localparam int FCNT_W = 2;
  localparam int RW     = COLS * WIDTH;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              ASYNCRESETN;
  logic [WIDTH-1:0]  I0 [COLS];
  logic              I_valid;
  logic              I_ready;
  logic [WIDTH-1:0]  O0 [ROWS][COLS];
  logic              O_valid;
  logic              O_ready;
  logic [FCNT_W-1:0] O_frames;
`ifdef NDPACK_LAST_CHECK_EN
  logic              I_last;
  logic              O_err;
`endif

  nd_array_row_packer #(
    .WIDTH (WIDTH),
    .COLS  (COLS),
    .ROWS  (ROWS),
    .FCNT_W(FCNT_W)
  ) dut (
    .CLK        (clk),
    .ASYNCRESETN(ASYNCRESETN),
    .I0         (I0),
    .I_valid    (I_valid),
    .I_ready    (I_ready),
`ifdef NDPACK_LAST_CHECK_EN
    .I_last     (I_last),
    .O_err      (O_err),
`endif
    .O0         (O0),
    .O_valid    (O_valid),
    .O_ready    (O_ready),
    .O_frames   (O_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard storage: model writes slots and wr_ptr, monitor owns rd_ptr.
  logic [WIDTH-1:0] exp_mem [DEPTH][ROWS][COLS];
  logic [WIDTH-1:0] m_cur [ROWS][COLS];
  int               m_cnt = 0;
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  int               exp_frames = 0;
  int               handoffs = 0;
  int               checks = 0;
  int               failures = 0;
  int               drv_timeouts = 0;
  int               drv_cnt = 0;
  bit               done = 0;

  // Reference model: collect accepted rows, every ROWS rows form one frame.
  always @(negedge clk) begin
    #3;
    if (!ASYNCRESETN) begin
      m_cnt = 0;
    end else if (I_valid && I_ready) begin
      for (int c = 0; c < COLS; c++) m_cur[m_cnt][c] = I0[c];
      m_cnt++;
      if (m_cnt == ROWS) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            exp_mem[wr_ptr % DEPTH][r][c] = m_cur[r][c];
        wr_ptr++;
        m_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  bit mon_bad;
  int mon_r;
  int mon_c;
  int mon_slot;
  bit mon_pend;

  always @(negedge clk) begin
    if (done) begin
      chk("driver_timeouts", 64'(drv_timeouts), 64'd0);
      chk("enough_handoffs", 64'(handoffs >= 10), 64'd1);
`ifdef NDPACK_LAST_CHECK_EN
      chk("O_err_clean", 64'(O_err), 64'd0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    if (!ASYNCRESETN) begin
      chk("reset_O_valid", 64'(O_valid), 64'd0);
      chk("reset_O_frames", 64'(O_frames), 64'd0);
      mon_bad = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (O0[r][c] !== '0) mon_bad = 1;
      chk("reset_O0_zero", 64'(mon_bad), 64'd0);
      rd_ptr     = wr_ptr;
      exp_frames = 0;
    end else begin
      mon_pend = (wr_ptr != rd_ptr);
      chk("O_valid", 64'(O_valid), 64'(mon_pend));
      chk("I_ready", 64'(I_ready), 64'(!mon_pend || O_ready));
      chk("O_frames", 64'(O_frames), 64'(exp_frames));
      if (mon_pend && O_valid === 1'b1) begin
        mon_slot = rd_ptr % DEPTH;
        mon_bad  = 0;
        mon_r    = 0;
        mon_c    = 0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (!mon_bad && O0[r][c] !== exp_mem[mon_slot][r][c]) begin
              mon_bad = 1;
              mon_r   = r;
              mon_c   = c;
            end
        checks++;
        if (mon_bad) begin
          failures++;
          $display("FAIL frame_data row %0d col %0d: got 0x%0h expected 0x%0h at %0t",
                   mon_r, mon_c, O0[mon_r][mon_c], exp_mem[mon_slot][mon_r][mon_c], $time);
        end
      end
      if (mon_pend && O_ready) begin
        rd_ptr++;
        handoffs++;
        exp_frames = (exp_frames + 1) % (1 << FCNT_W);
      end
    end
  end

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic cycle(input bit v, input bit ordy, output bit took);
    I_valid = v;
    O_ready = ordy;
`ifdef NDPACK_LAST_CHECK_EN
    I_last  = (drv_cnt == ROWS - 1);
`endif
    @(negedge clk);
    #2;
    took = v && I_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [RW-1:0] r, input bit rnd_ordy);
    bit took;
    int n;
    took = 0;
    n    = 0;
    for (int c = 0; c < COLS; c++) I0[c] = r[c*WIDTH +: WIDTH];
    while (!took && n < 50) begin
      cycle(1'b1, rnd_ordy ? 1'($urandom_range(0, 1)) : 1'b1, took);
      n++;
    end
    if (!took) drv_timeouts++;
    else       drv_cnt = (drv_cnt + 1) % ROWS;
  endtask

  task automatic do_reset();
    #2;
    ASYNCRESETN = 1'b0;
    I_valid     = 1'b0;
    drv_cnt     = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    ASYNCRESETN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit took;
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit took;
    ASYNCRESETN = 1'b1;
    I_valid     = 1'b0;
    O_ready     = 1'b0;
`ifdef NDPACK_LAST_CHECK_EN
    I_last      = 1'b0;
`endif
    for (int c = 0; c < COLS; c++) I0[c] = '0;
    #1 ASYNCRESETN = 1'b0;
    repeat (2) @(posedge clk);
    #3 ASYNCRESETN = 1'b1;
    @(posedge clk);
    #1;

    // Directed frame {01,02},{03,04},{05,06},{07,08}
    send_row(16'h0201, 1'b0);
    send_row(16'h0403, 1'b0);
    send_row(16'h0605, 1'b0);
    send_row(16'h0807, 1'b0);
    cycle(1'b0, 1'b1, took);

    // Back-to-back frames with continuous valid and ready
    for (int i = 0; i < 3 * ROWS; i++) send_row(RW'($urandom), 1'b0);

    // Backpressure: full frame held while a new row waits
    for (int i = 0; i < ROWS; i++) send_row(RW'($urandom), 1'b0);
    for (int c = 0; c < COLS; c++) I0[c] = WIDTH'(8'hA0 + c);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, took);
    send_row(16'hA1A0, 1'b0);
    for (int i = 1; i < ROWS; i++) send_row(RW'($urandom), 1'b0);
    cycle(1'b0, 1'b1, took);

    // Reset in the middle of a frame
    send_row(RW'($urandom), 1'b0);
    send_row(RW'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < ROWS; i++) send_row(RW'($urandom), 1'b0);
    cycle(1'b0, 1'b1, took);

    // Randomized traffic on both handshakes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) send_row(RW'($urandom), 1'b1);
      else cycle(1'b0, 1'($urandom_range(0, 1)), took);
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, took);
    done = 1;
    @(negedge clk);
    #1;
  end

endmodule
`default_nettype wire
